// File: rtl/vga_pattern_scroller.sv
// 640x480@60 VGA timing generator that paints a scrolling colour pattern.
// Scroll controls are sampled once per frame so each frame is drawn with one consistent setting.
module vga_pattern_scroller #(
    parameter int COLOR_BITS = 2,
    parameter int OFS_W      = 10,
    parameter int SHIFT      = 5,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [2:0]            speed,
    input  logic                  dir,
    input  logic                  pause,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  frame_tick
);

    localparam int CNT_W   = 10;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] hpos_reg;
    logic [CNT_W-1:0] vpos_reg;
    logic [OFS_W-1:0] offset_reg;
    logic [OFS_W-1:0] offset_next;
    logic [1:0]       mode_reg;
    logic [2:0]       speed_reg;
    logic             dir_reg;
    logic             pause_reg;

    logic [OFS_W-1:0] pattern;
    logic [OFS_W-1:0] coord;
    logic [2:0][COLOR_BITS-1:0] chan;
    logic             unused_bits;

    assign frame_tick = (hpos_reg == H_LAST) && (vpos_reg == V_LAST);
    assign display_on = (hpos_reg < H_VIS) && (vpos_reg < V_VIS);
    assign hsync      = !((hpos_reg >= HS_START) && (hpos_reg <= HS_END));
    assign vsync      = !((vpos_reg >= VS_START) && (vpos_reg <= VS_END));

    // The step uses the live inputs so the update lands on the same edge they are sampled.
    always_comb begin
        offset_next = offset_reg;
        if (!pause && (speed != 3'd0)) begin
            offset_next = dir ? (offset_reg - OFS_W'(speed)) : (offset_reg + OFS_W'(speed));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_reg   <= '0;
            vpos_reg   <= '0;
            offset_reg <= '0;
            mode_reg   <= '0;
            speed_reg  <= '0;
            dir_reg    <= 1'b0;
            pause_reg  <= 1'b0;
        end else begin
            if (hpos_reg == H_LAST) begin
                hpos_reg <= '0;
                vpos_reg <= (vpos_reg == V_LAST) ? '0 : vpos_reg + CNT_W'(1);
            end else begin
                hpos_reg <= hpos_reg + CNT_W'(1);
            end
            if (frame_tick) begin
                mode_reg   <= mode;
                speed_reg  <= speed;
                dir_reg    <= dir;
                pause_reg  <= pause;
                offset_reg <= offset_next;
            end
        end
    end

    always_comb begin
        case (mode_reg)
            2'd0:    pattern = OFS_W'(hpos_reg);
            2'd1:    pattern = OFS_W'(vpos_reg);
            2'd2:    pattern = OFS_W'(hpos_reg) + OFS_W'(vpos_reg);
            default: pattern = OFS_W'(hpos_reg ^ vpos_reg);
        endcase
        coord = pattern + offset_reg;
    end

    // Channels r, g, b take overlapping windows of the coordinate, one bit apart.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = display_on ? coord[SHIFT + gi +: COLOR_BITS] : '0;
        end
    endgenerate

    assign r = chan[0];
    assign g = chan[1];
    assign b = chan[2];

    // Shadow copies of speed/dir/pause are kept for observability only.
    assign unused_bits = ^{coord, speed_reg, dir_reg, pause_reg};

endmodule

// File: tb/tb_vga_pattern_scroller.sv
// Bench: a full-size instance for line timing and a reduced-geometry instance for multi-frame scrolling.
module tb_vga_pattern_scroller;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       dir;
    logic       pause;

    logic       hsync, vsync, display_on, frame_tick;
    logic [1:0] r, g, b;
    logic       hsync_f, vsync_f, display_on_f, frame_tick_f;
    logic [1:0] r_f, g_f, b_f;

    // Small geometry: 48 x 14 total, 32 x 8 visible, hsync 36..43, vsync 10..11.
    localparam int SH_T = 48;
    localparam int SV_T = 14;

    vga_pattern_scroller #(
        .H_ACTIVE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .dir(dir), .pause(pause),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .r(r), .g(g), .b(b), .frame_tick(frame_tick)
    );

    vga_pattern_scroller dut_full (
        .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .dir(dir), .pause(pause),
        .hsync(hsync_f), .vsync(vsync_f), .display_on(display_on_f),
        .r(r_f), .g(g_f), .b(b_f), .frame_tick(frame_tick_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int sh, sv, soff;
    logic [1:0] smode;
    int fh, fv;
    int hs_low_f, vs_low, ft_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (small h=%0d v=%0d)", name, act, exp, sh, sv);
        end
    endtask

    task automatic check_pixels();
        int pat, coord;
        logic de, hs, vs, ft, fde, fhs, fvs, fft;
        logic [1:0] er, eg, eb;
        de = (sh < 32) && (sv < 8);
        hs = !((sh >= 36) && (sh <= 43));
        vs = !((sv >= 10) && (sv <= 11));
        ft = (sh == SH_T - 1) && (sv == SV_T - 1);
        case (smode)
            2'd0:    pat = sh;
            2'd1:    pat = sv;
            2'd2:    pat = sh + sv;
            default: pat = sh ^ sv;
        endcase
        coord = (pat + soff) & 1023;
        er = de ? 2'(coord >> 5) : 2'b00;
        eg = de ? 2'(coord >> 6) : 2'b00;
        eb = de ? 2'(coord >> 7) : 2'b00;
        chk("pix_small", 32'({hsync, vsync, display_on, frame_tick, r, g, b}),
            32'({hs, vs, de, ft, er, eg, eb}));
        fde = (fh < 640) && (fv < 480);
        fhs = !((fh >= 656) && (fh <= 751));
        fvs = !((fv >= 490) && (fv <= 491));
        fft = (fh == 799) && (fv == 524);
        chk("pix_full", 32'({hsync_f, vsync_f, display_on_f, frame_tick_f}),
            32'({fhs, fvs, fde, fft}));
    endtask

    // One clock: update the reference on the edge, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (sh == SH_T - 1 && sv == SV_T - 1) begin
            smode = mode;
            if (!pause && speed != 3'd0)
                soff = dir ? ((soff - int'(speed)) & 1023) : ((soff + int'(speed)) & 1023);
        end
        if (sh == SH_T - 1) begin
            sh = 0;
            sv = (sv == SV_T - 1) ? 0 : sv + 1;
        end else begin
            sh++;
        end
        if (fh == 799) begin
            fh = 0;
            fv = (fv == 524) ? 0 : fv + 1;
        end else begin
            fh++;
        end
        @(negedge clk);
        if (!hsync_f) hs_low_f++;
        if (!vsync) vs_low++;
        if (frame_tick) ft_cnt++;
        check_pixels();
    endtask

    task automatic next_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!(sh == 0 && sv == 0) && n < 2000);
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL frame_start_timeout: got h=%0d v=%0d expected h=0 v=0", sh, sv);
        end
    endtask

    task automatic goto_pos(input int h, input int v);
        int n = 0;
        while (!(sh == h && sv == v) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL goto_timeout: got h=%0d v=%0d expected h=%0d v=%0d", sh, sv, h, v);
        end
    endtask

    task automatic reset_model();
        sh = 0; sv = 0; soff = 0; smode = 2'd0; fh = 0; fv = 0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] speed;
        logic       dir;
        logic       pause;
        int         h;
        int         v;
        int         off;
        logic [1:0] er;
        logic [1:0] eg;
        logic [1:0] eb;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Each entry: inputs applied mid-frame, offset after the next tick, colour at (h,v).
        vecs[0] = '{2'd0, 3'd3, 1'b0, 1'b0, 29, 0, 3,    2'd1, 2'd0, 2'd0};
        vecs[1] = '{2'd0, 3'd3, 1'b0, 1'b0, 26, 0, 6,    2'd1, 2'd0, 2'd0};
        vecs[2] = '{2'd1, 3'd7, 1'b1, 1'b0, 5,  0, 1023, 2'd3, 2'd3, 2'd3};
        vecs[3] = '{2'd2, 3'd1, 1'b0, 1'b0, 31, 7, 0,    2'd1, 2'd0, 2'd0};
        vecs[4] = '{2'd3, 3'd5, 1'b0, 1'b0, 23, 7, 5,    2'd0, 2'd0, 2'd0};
        vecs[5] = '{2'd3, 3'd5, 1'b0, 1'b1, 28, 3, 5,    2'd1, 2'd0, 2'd0};
        vecs[6] = '{2'd0, 3'd4, 1'b1, 1'b0, 31, 0, 1,    2'd1, 2'd0, 2'd0};
        vecs[7] = '{2'd1, 3'd0, 1'b0, 1'b0, 10, 6, 1,    2'd0, 2'd0, 2'd0};

        rst_n = 1'b0; mode = 2'd0; speed = 3'd0; dir = 1'b0; pause = 1'b0;
        reset_model();
        hs_low_f = 0; vs_low = 0; ft_cnt = 0;

        repeat (2) @(negedge clk);
        chk("reset_out_small", 32'({hsync, vsync, display_on, frame_tick, r, g, b}), 32'({4'b1110, 6'd0}));
        chk("reset_out_full", 32'({hsync_f, vsync_f, display_on_f, frame_tick_f}), 32'(4'b1110));
        chk("reset_state", {dut.hpos_reg, dut.vpos_reg, dut.offset_reg, dut.mode_reg}, 32'd0);

        rst_n = 1'b1;
        check_pixels();
        hs_low_f = 0;
        repeat (800) step();
        chk("hsync_low_cycles", 32'(hs_low_f), 32'd96);
        chk("full_line_wrap", 32'({dut_full.hpos_reg, dut_full.vpos_reg}), 32'({10'd0, 10'd1}));

        foreach (vecs[i]) begin
            mode = vecs[i].mode; speed = vecs[i].speed; dir = vecs[i].dir; pause = vecs[i].pause;
            next_frame();
            goto_pos(vecs[i].h, vecs[i].v);
            chk($sformatf("vec%0d_offset", i), 32'(dut.offset_reg), 32'(vecs[i].off));
            chk($sformatf("vec%0d_rgb", i), 32'({r, g, b}), 32'({vecs[i].er, vecs[i].eg, vecs[i].eb}));
        end

        // Mid-frame input glitches must be invisible; only values present at the tick count.
        mode = 2'd2; speed = 3'd7; dir = 1'b0; pause = 1'b0;
        repeat (50) step();
        mode = 2'd3; speed = 3'd0;
        next_frame();
        goto_pos(30, 5);
        chk("glitch_offset", 32'(dut.offset_reg), 32'd1);
        chk("glitch_mode", 32'(dut.mode_reg), 32'd3);

        // Asynchronous reset mid-frame, checked before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_state", {dut.hpos_reg, dut.vpos_reg, dut.offset_reg, dut.mode_reg}, 32'd0);
        chk("async_reset_out", 32'({hsync, vsync, display_on, frame_tick, r, g, b}), 32'({4'b1110, 6'd0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mode = 2'd0; speed = 3'd0;
        reset_model();
        step();
        chk("post_reset_pos", 32'({dut.hpos_reg, dut.vpos_reg}), 32'({10'd1, 10'd0}));

        vs_low = 0; ft_cnt = 0;
        repeat (SH_T * SV_T) step();
        chk("vsync_low_cycles", 32'(vs_low), 32'(2 * SH_T));
        chk("frame_ticks_per_frame", 32'(ft_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
